// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// instr_encoder_pkg : shared formats, error codes and opcodes for instr_encoder
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] U_TYPE  = 7'b0110111;
  localparam logic [6:0] J_TYPE  = 7'b1101111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
// ============================================================================
// imm_pack : combinational RV32I field packing with immediate range checks
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  func3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [1:0]  code
);

  always_comb begin
    word = 32'd0;
    code = ERR_NONE;
    case (fmt)
      FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, func3, rd, opcode};
        if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        // range is judged first so an odd out-of-range offset reports range
        if (!in_range(imm, -4096, 4094)) code = ERR_RANGE;
        else if (imm[0])                 code = ERR_ALIGN;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) code = ERR_ALIGN;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!in_range(imm, -1048576, 1048574)) code = ERR_RANGE;
        else if (imm[0])                       code = ERR_ALIGN;
      end
      default: code = ERR_FMT;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : streams packed RV32I words into sequential memory addresses
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_func3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic              wrapped,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e      state;
  logic [31:0] packed_word;
  logic [1:0]  pack_code;
  logic        accept;
  logic        complete;

  imm_pack u_imm_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .func3  (in_func3),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .func7  (in_func7),
    .imm    (in_imm),
    .word   (packed_word),
    .code   (pack_code)
  );

  // start and finish both pre-empt acceptance in the cycle they are raised
  assign in_ready = (state == ST_RUN) && !start && !finish && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign complete = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'd0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      count     <= '0;
      wrapped   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= ST_RUN;
        mem_we   <= 1'b0;
        mem_addr <= BASE;
        err      <= 1'b0;
        err_code <= ERR_NONE;
        count    <= '0;
        wrapped  <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (complete) begin
          mem_we   <= 1'b0;
          mem_addr <= mem_addr + 1'b1;
          if (mem_addr == ADDR_MAX) wrapped <= 1'b1;
          if (count != '1) count <= count + 1'b1;
        end
        if (accept) begin
          if (pack_code != ERR_NONE) begin
            err <= 1'b1;
            if (err_code == ERR_NONE) err_code <= pack_code;
          end else begin
            mem_we    <= 1'b1;
            mem_wdata <= packed_word;
          end
        end
        if (state == ST_RUN && finish) begin
          state <= ST_DRAIN;
        end else if (state == ST_DRAIN && (!mem_we || mem_ready)) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder : directed bench for instr_encoder with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  localparam int AW   = 2;
  localparam int AMAX = (1 << AW) - 1;
  localparam int CMAX = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, finish, in_valid, in_ready;
  logic [2:0]    in_fmt, in_func3;
  logic [6:0]    in_opcode, in_func7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we, mem_ready, err, wrapped, done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_func3(in_func3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func7(in_func7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .err(err), .err_code(err_code), .count(count),
    .wrapped(wrapped), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit [31:0] m_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm);
    bit [31:0] i;
    bit [31:0] b;
    i = imm;
    b = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
    case (f)
      3'd0: return b + (32'(rd) << 7) + (32'(rs2) << 20) + (32'(f7) << 25);
      3'd1: return b + (32'(rd) << 7) + ((i & 32'hFFF) << 20);
      3'd2: return b + ((i & 31) << 7) + (32'(rs2) << 20) + (((i >> 5) & 127) << 25);
      3'd3: return b + (((i >> 11) & 1) << 7) + (((i >> 1) & 15) << 8) + (32'(rs2) << 20)
                     + (((i >> 5) & 63) << 25) + (((i >> 12) & 1) << 31);
      3'd4: return 32'(op) + (32'(rd) << 7) + (i & 32'hFFFFF000);
      3'd5: return 32'(op) + (32'(rd) << 7) + (((i >> 12) & 255) << 12) + (((i >> 11) & 1) << 20)
                     + (((i >> 1) & 1023) << 21) + (((i >> 20) & 1) << 31);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_code(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (f)
      3'd0: return 0;
      3'd1, 3'd2: return (s < -2048 || s > 2047) ? 1 : 0;
      3'd3: return (s < -4096 || s > 4094) ? 1 : ((s % 2 != 0) ? 2 : 0);
      3'd4: return ((s & 4095) != 0) ? 2 : 0;
      3'd5: return (s < -(1 << 20) || s > (1 << 20) - 2) ? 1 : ((s % 2 != 0) ? 2 : 0);
      default: return 3;
    endcase
  endfunction

  int        m_mode;   // 0 idle, 1 run, 2 drain
  bit        m_we, m_err, m_wrapped, m_done;
  int        m_addr, m_count, m_code_r;
  bit [31:0] m_data;

  function automatic bit m_ready();
    return (m_mode == 1) && !start && !finish && (!m_we || mem_ready);
  endfunction

  always @(posedge clk) begin : model
    bit rdy, old_we;
    int c;
    if (!rst_n) begin
      m_mode = 0; m_we = 0; m_addr = 0; m_data = 0; m_err = 0;
      m_code_r = 0; m_count = 0; m_wrapped = 0; m_done = 0;
    end else begin
      rdy    = m_ready();
      old_we = m_we;
      m_done = 0;
      if (start) begin
        m_mode = 1; m_we = 0; m_addr = 0; m_err = 0;
        m_code_r = 0; m_count = 0; m_wrapped = 0;
      end else if (m_mode != 0) begin
        if (m_we && mem_ready) begin
          if (m_addr == AMAX) m_wrapped = 1;
          m_addr  = (m_addr + 1) % (AMAX + 1);
          m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
          m_we    = 0;
        end
        if (in_valid && rdy) begin
          c = m_code(in_fmt, in_imm);
          if (c != 0) begin
            m_err = 1;
            if (m_code_r == 0) m_code_r = c;
          end else begin
            m_we   = 1;
            m_data = m_enc(in_fmt, in_opcode, in_rd, in_func3, in_rs1, in_rs2, in_func7, in_imm);
          end
        end
        if (m_mode == 1 && finish) m_mode = 2;
        else if (m_mode == 2 && (!old_we || mem_ready)) begin
          m_mode = 0;
          m_done = 1;
        end
      end
    end
  end

  bit [31:0] log_data[$];
  int        log_addr[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  32'(in_ready),  32'(m_ready()));
      chk("mem_we",    32'(mem_we),    32'(m_we));
      chk("mem_addr",  32'(mem_addr),  m_addr);
      chk("mem_wdata", mem_wdata,      m_data);
      chk("err",       32'(err),       32'(m_err));
      chk("err_code",  32'(err_code),  m_code_r);
      chk("count",     32'(count),     m_count);
      chk("wrapped",   32'(wrapped),   32'(m_wrapped));
      chk("done",      32'(done),      32'(m_done));
      if (mem_we && mem_ready) begin
        log_data.push_back(mem_wdata);
        log_addr.push_back(int'(mem_addr));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input int f, input int op, input int rd, input int f3,
                     input int rs1, input int rs2, input int f7, input int imm);
    in_fmt = 3'(f); in_opcode = 7'(op); in_rd = 5'(rd); in_func3 = 3'(f3);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_func7 = 7'(f7); in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int f, input int op, input int rd, input int f3,
                      input int rs1, input int rs2, input int f7, input int imm);
    put(f, op, rd, f3, rs1, rs2, f7, imm);
    wait_accept();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic int dec_b(input bit [31:0] w);
    return (w[31] ? -4096 : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
  endfunction

  function automatic int dec_j(input bit [31:0] w);
    return (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
           + (int'(w[30:21]) << 1);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // model pins: hand-computed encodings
    chk("model_I", m_enc(1, 7'h13, 1, 0, 0, 0, 0, 5), 32'h00500093);
    chk("model_B", m_enc(3, 7'h63, 0, 0, 0, 0, 0, -4), 32'hFE000EE3);
    chk("model_Bcode", m_code(3, 4095), 32'd1);

    // back-to-back burst across the address wrap
    pulse_start();
    send(1, 7'h13, 1, 0, 0, 0, 0, 5);
    send(2, 7'h23, 0, 2, 1, 2, 0, 8);
    send(3, 7'h63, 0, 0, 0, 0, 0, -4);
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    send(5, 7'h6F, 0, 0, 0, 0, 0, 8);
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("log_size", log_data.size(), 32'd5);
    if (log_data.size() >= 5) begin
      chk("wr_I", log_data[0], 32'h00500093);
      chk("wr_S", log_data[1], 32'h0020A423);
      chk("wr_B", log_data[2], 32'hFE000EE3);
      chk("wr_U", log_data[3], 32'h123452B7);
      chk("wr_J", log_data[4], 32'h0080006F);
      chk("addr_S", log_addr[1], 32'd1);
      chk("addr_wrap", log_addr[4], 32'd0);
      chk("dec_B", dec_b(log_data[2]), -4);
      chk("dec_J", dec_j(log_data[4]), 8);
    end
    chk("count5", 32'(count), 32'd5);
    chk("wrapped1", 32'(wrapped), 32'd1);

    // rejected inputs: first code sticks, nothing written
    send(1, 7'h13, 1, 0, 0, 0, 0, 2048);
    send(3, 7'h63, 0, 0, 0, 0, 0, 3);
    idle_in();
    @(posedge clk); #1;
    chk("err_range", 32'(err_code), 32'd1);
    chk("err_count", 32'(count), 32'd5);

    // stall with a pending word, then release and run 1/cycle
    mem_ready = 1'b0;
    send(1, 7'h13, 2, 0, 0, 0, 0, -2048);
    put(1, 7'h13, 3, 0, 0, 0, 0, 2047);
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_we", 32'(mem_we), 32'd1);
    end
    mem_ready = 1'b1;
    wait_accept();
    send(3, 7'h63, 0, 1, 2, 3, 0, 4094);
    send(3, 7'h63, 0, 1, 2, 3, 0, -4096);
    send(5, 7'h6F, 1, 0, 0, 0, 0, 1048574);
    send(5, 7'h6F, 1, 0, 0, 0, 0, -1048576);
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("count_sat", 32'(count), 32'(CMAX));

    // finish while a write is stalled
    mem_ready = 1'b0;
    send(4, 7'h37, 3, 0, 0, 0, 0, 32'hABCDE000);
    idle_in();
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_no_done", 32'(done), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("done_clear", 32'(done), 32'd0);

    // start during a stalled write discards it
    pulse_start();
    mem_ready = 1'b0;
    send(0, 7'h33, 3, 0, 1, 2, 7'h20, 0);
    idle_in();
    @(posedge clk); #1;
    chk("wr_R", mem_wdata, 32'h402081B3);
    pulse_start();
    chk("discard_we", 32'(mem_we), 32'd0);
    chk("discard_cnt", 32'(count), 32'd0);
    mem_ready = 1'b1;

    // error-code priority cases
    send(5, 7'h6F, 0, 0, 0, 0, 0, 3);
    send(7, 7'h13, 0, 0, 0, 0, 0, 0);
    idle_in();
    @(posedge clk); #1;
    chk("err_align", 32'(err_code), 32'd2);
    pulse_start();
    send(6, 7'h13, 0, 0, 0, 0, 0, 0);
    idle_in();
    @(posedge clk); #1;
    chk("err_fmt", 32'(err_code), 32'd3);
    pulse_start();
    send(3, 7'h63, 0, 0, 0, 0, 0, 4095);
    send(1, 7'h13, 1, 0, 0, 0, 0, 1);
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("err_b_range", 32'(err_code), 32'd1);
    chk("cnt_after_err", 32'(count), 32'd1);

    // reset in the middle of a stalled write
    mem_ready = 1'b0;
    send(1, 7'h13, 4, 0, 0, 0, 0, 7);
    idle_in();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the instruction decoder. Accepts field-level instruction descriptions (format, opcode, rd, func3, rs1, rs2, func7, signed immediate) over a valid/ready handshake, range-checks and packs the immediate per format, and writes the 32-bit words to sequential instruction-memory addresses. Used by the boot/program loader and by the core testbench to build instruction memory images.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `BASE_ADDR`, 0: first word address after `start`.

- `clk` in 1: clock.
- `rst_n` in 1: synchronous reset, active low.
- `start` in 1: pulse; clears counter and flags, enters RUN.
- `finish` in 1: pulse in RUN; drain, then return to IDLE.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `in_fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal.
- `in_opcode` in 7, `in_rd` in 5, `in_func3` in 3, `in_rs1` in 5, `in_rs2` in 5, `in_func7` in 7: raw fields.
- `in_imm` in 32: signed immediate (byte offset for B/J; full value for U).
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32: write port.
- `mem_ready` in 1: memory accepts the write this cycle.
- `err` out 1: sticky, set on any rejected input.
- `err_code` out 2: first error: 0 none, 1 out of range, 2 misaligned / nonzero low bits, 3 illegal format.
- `count` out ADDR_W+1: words written since `start`.
- `wrapped` out 1: sticky, address wrapped past 2^ADDR_W−1.
- `done` out 1: one-cycle pulse on leaving DRAIN.

## Operation
- States: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE: `in_ready`=0. `start` → RUN. Same edge: address = BASE_ADDR, `count`/`err`/`err_code`/`wrapped` = 0.
- RUN: `in_ready = !mem_we || mem_ready`.
  - `finish` → DRAIN. Inputs are not accepted in the `finish` cycle.
- DRAIN: `in_ready`=0. When `mem_we` is low or `mem_ready` is high → IDLE, `done`=1 for one cycle.
- `start` in RUN or DRAIN: priority over everything. The pending word is discarded (`mem_we`→0), then counters and flags are re-initialised, state RUN.
- Packing: rd→[11:7], func3→[14:12], rs1→[19:15], rs2→[24:20], func7→[31:25], opcode→[6:0]. Each format uses only its own fields.
  - R: ignores `in_imm`.
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→[31], imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→[7].
  - U: imm[31:12]→[31:12].
  - J: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12].
- Checks (signed):
  - I/S: −2048..2047.
  - B: −4096..4094, bit0 = 0.
  - J: −2^20..2^20−2, bit0 = 0.
  - U: imm[11:0] must be 0 (code 2).
  - Range is checked before alignment. Illegal format gives code 3.
- Rejected input:
  - Still handshaken (consumed), nothing written, address unchanged.
  - `err`=1. `err_code` latches only while it is 0.
- Address advances on each completed write (`mem_we && mem_ready`), modulo 2^ADDR_W.
  - A write at 2^ADDR_W−1 sets `wrapped`; the next address is 0.
  - `count` increments on each completed write and saturates at 2^(ADDR_W+1)−1.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` BASE_ADDR, `mem_wdata` 0, `err` 0, `err_code` 0, `count` 0, `wrapped` 0, `done` 0.
- Latency: input accepted at edge t → `mem_we`=1 with data/address from t+1.
  - Output held stable until `mem_ready` is sampled high.
- Throughput: 1 word/cycle while `mem_ready` stays high.
  - A simultaneous accept and complete replaces the output register in the same edge.
- Flags update on the edge that accepts or completes the transaction.

## Structure
- Shared package / opcode definitions:
  - format enum `fmt_e` (R..J);
  - error-code constants;
  - opcode constants (`I_TYPE`, `S_TYPE`, `B_TYPE`, `U_TYPE`, `J_TYPE`, load 0000011, jalr 1100111).
- Sub-module `imm_pack`: combinational packing plus range/alignment check, outputs `{word, err_code}`.
- Top level: FSM, output register, address counter.

## Test plan
- I: opcode 0010011, rd=1, func3=0, rs1=0, imm=5 → `mem_wdata`=0x00500093 at BASE_ADDR, t+1. Then S (sw x2,8(x1)): 0x0020A423 at BASE_ADDR+1.
- B (beq x0,x0,−4) → 0xFE000EE3. U (lui x5,0x12345000) → 0x123452B7. J (jal x0,8) → 0x0080006F. Each output word fed through the decoder returns the original fields and immediate.
- I imm=2048 → `err`=1, code 1, no write. Next: B imm=3 → code stays 1, no write. `count` unchanged.
- `mem_ready` low 3 cycles → `mem_we`/`mem_addr`/`mem_wdata` stable, `in_ready`=0. Release → one write, then back-to-back writes at 1/cycle.
- ADDR_W=2: 5 valid words → addresses 0,1,2,3,0, `wrapped`=1, `count`=5.
- `finish` with a stalled write → DRAIN until `mem_ready`, then `done` pulse. `start` mid-stall → word discarded, counters cleared. `rst_n` low mid-write → all outputs at reset values next edge.
